controle_principal_mc: RTL and testbench

- Main control FSM for the multicycle MIPS datapath. It is the initiator side of the OpALU interface consumed by the ALU control decoder.
- Decodes the 6-bit instruction opcode and sequences fetch/decode/execute/memory/writeback. Emits OpALU, mux selects and write enables each cycle.
- Supports R-type, lw, sw, beq, j and addi. Stalls on a memory-ready handshake.

---
 rtl/controle_principal_mc_pkg.sv | 26 ++
 rtl/controle_principal_mc_if.sv | 22 ++
 rtl/controle_principal_mc_saidas.sv | 29 ++
 rtl/controle_principal_mc.sv | 58 +++++
 tb/tb_controle_principal_mc.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/controle_principal_mc_pkg.sv
// controle_pkg: opcodes, state encodings, ALU op codes and control word for the multicycle MIPS controller
package controle_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADDR = 4'd2, S_MEMRD = 4'd3,
    S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_EXEC = 4'd6, S_RDONE = 4'd7,
    S_BRANCH = 4'd8, S_JUMP = 4'd9, S_ADDI_EX = 4'd10, S_ADDI_WB = 4'd11
  } state_t;
  typedef struct packed {
    logic [1:0] OpALU;
    logic       RegDst, ALUSrcA, IorD, MemtoReg;
    logic [1:0] ALUSrcB, PCSource;
    logic       MemRead, MemWrite, IRWrite, RegWrite, PCWrite, PCWriteCond, instr_done;
  } ctrl_t;
  function automatic logic is_legal(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
  endfunction
endpackage

// File: rtl/controle_principal_mc_if.sv
// controle_principal_mc_if: opcode/mem handshake in, datapath control word out
interface controle_principal_mc_if #(parameter int OPC_W = 6);
  logic [OPC_W-1:0] opcode;
  logic             mem_ready;
  logic [1:0]       OpALU, ALUSrcB, PCSource;
  logic             RegDst, ALUSrcA, IorD, MemtoReg;
  logic             MemRead, MemWrite, IRWrite, RegWrite, PCWrite, PCWriteCond;
  logic             illegal_op, instr_done;
  logic [3:0]       state_o;
  modport master (
    input  opcode, mem_ready,
    output OpALU, ALUSrcB, PCSource, RegDst, ALUSrcA, IorD, MemtoReg,
           MemRead, MemWrite, IRWrite, RegWrite, PCWrite, PCWriteCond,
           illegal_op, instr_done, state_o
  );
  modport slave (
    output opcode, mem_ready,
    input  OpALU, ALUSrcB, PCSource, RegDst, ALUSrcA, IorD, MemtoReg,
           MemRead, MemWrite, IRWrite, RegWrite, PCWrite, PCWriteCond,
           illegal_op, instr_done, state_o
  );
endinterface

// File: rtl/controle_principal_mc_saidas.sv
// controle_saidas: state-to-control-word decoder; en low forces the whole word to zero
module controle_saidas
  import controle_pkg::*;
(
  input  state_t state,
  input  logic   mr,
  input  logic   en,
  output ctrl_t  c
);
  always_comb begin
    c = '0;
    case (state)
      S_FETCH:   begin c.MemRead = 1'b1; c.ALUSrcB = 2'b01; c.IRWrite = mr; c.PCWrite = mr; end
      S_DECODE:  c.ALUSrcB = 2'b11;
      S_MEMADDR: begin c.ALUSrcA = 1'b1; c.ALUSrcB = 2'b10; end
      S_MEMRD:   begin c.MemRead = 1'b1; c.IorD = 1'b1; end
      S_MEMWB:   begin c.MemtoReg = 1'b1; c.RegWrite = 1'b1; c.instr_done = 1'b1; end
      S_MEMWR:   begin c.MemWrite = 1'b1; c.IorD = 1'b1; c.instr_done = mr; end
      S_EXEC:    begin c.ALUSrcA = 1'b1; c.OpALU = ALUOP_FUNCT; end
      S_RDONE:   begin c.RegDst = 1'b1; c.RegWrite = 1'b1; c.instr_done = 1'b1; end
      S_BRANCH:  begin c.ALUSrcA = 1'b1; c.OpALU = ALUOP_SUB; c.PCWriteCond = 1'b1; c.PCSource = 2'b01; c.instr_done = 1'b1; end
      S_JUMP:    begin c.PCWrite = 1'b1; c.PCSource = 2'b10; c.instr_done = 1'b1; end
      S_ADDI_EX: begin c.ALUSrcA = 1'b1; c.ALUSrcB = 2'b10; end
      S_ADDI_WB: begin c.RegWrite = 1'b1; c.instr_done = 1'b1; end
      default:   c = '0;
    endcase
    if (!en) c = '0;
  end
endmodule

// File: rtl/controle_principal_mc.sv
// controle_principal_mc: main multicycle MIPS control FSM (fetch/decode/execute/mem/writeback)
module controle_principal_mc
  import controle_pkg::*;
#(
  parameter int OPC_W       = 6,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input logic clk,
  input logic rst_n,
  controle_principal_mc_if.master bus
);
  state_t           state;
  ctrl_t            c;
  logic [OPC_W-1:0] op;
  logic             mr;
  logic             illegal_q;
  assign op = bus.opcode;
  assign mr = MEM_WAIT_EN ? bus.mem_ready : 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= state == S_DECODE && !is_legal(op);
      case (state)
        S_FETCH:   state <= mr ? S_DECODE : S_FETCH;
        S_DECODE:  state <= (op == OP_LW || op == OP_SW) ? S_MEMADDR :
                            op == OP_RTYPE ? S_EXEC   :
                            op == OP_BEQ   ? S_BRANCH :
                            op == OP_J     ? S_JUMP   :
                            op == OP_ADDI  ? S_ADDI_EX : S_FETCH;
        S_MEMADDR: state <= op == OP_LW ? S_MEMRD : op == OP_SW ? S_MEMWR : S_FETCH;
        S_MEMRD:   state <= mr ? S_MEMWB : S_MEMRD;
        S_MEMWR:   state <= mr ? S_FETCH : S_MEMWR;
        S_EXEC:    state <= S_RDONE;
        S_ADDI_EX: state <= S_ADDI_WB;
        default:   state <= S_FETCH;
      endcase
    end
  // outputs are gated by rst_n so reset clears every enable without waiting for a clock
  controle_saidas u_saidas (.state(state), .mr(mr), .en(rst_n), .c(c));
  assign bus.OpALU       = c.OpALU;
  assign bus.RegDst      = c.RegDst;
  assign bus.ALUSrcA     = c.ALUSrcA;
  assign bus.IorD        = c.IorD;
  assign bus.MemtoReg    = c.MemtoReg;
  assign bus.ALUSrcB     = c.ALUSrcB;
  assign bus.PCSource    = c.PCSource;
  assign bus.MemRead     = c.MemRead;
  assign bus.MemWrite    = c.MemWrite;
  assign bus.IRWrite     = c.IRWrite;
  assign bus.RegWrite    = c.RegWrite;
  assign bus.PCWrite     = c.PCWrite;
  assign bus.PCWriteCond = c.PCWriteCond;
  assign bus.instr_done  = c.instr_done;
  assign bus.illegal_op  = illegal_q;
  assign bus.state_o     = state;
endmodule

// File: tb/tb_controle_principal_mc.sv
// tb_controle_principal_mc: random instruction stream checked against an instruction-level control model
module tb_controle_principal_mc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  logic pend = 1'b0;
  int   n_done, n_rw;
  always #5 clk = ~clk;
  controle_principal_mc_if #(.OPC_W(6)) bus ();
  controle_principal_mc #(.OPC_W(6), .MEM_WAIT_EN(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BQ = 6'b000100, JP = 6'b000010, AI = 6'b001000;

  function automatic logic legal(input logic [5:0] o);
    return o == LW || o == SW || o == RT || o == BQ || o == JP || o == AI;
  endfunction

  // {OpALU,RegDst,ALUSrcA,IorD,MemtoReg,ALUSrcB,PCSource,MemRead,MemWrite,IRWrite,RegWrite,PCWrite,PCWriteCond,instr_done}
  function automatic logic [16:0] expv(input int s, input logic mr);
    logic [1:0] alu = 0, srcb = 0, pcs = 0;
    logic rd = 0, sa = 0, iod = 0, m2r = 0, mrd = 0, mw = 0, irw = 0, rw = 0, pw = 0, pwc = 0, dn = 0;
    if (s == 0) begin mrd = 1; srcb = 2'b01; irw = mr; pw = mr; end
    if (s == 1) srcb = 2'b11;
    if (s == 2) begin sa = 1; srcb = 2'b10; end
    if (s == 3) begin mrd = 1; iod = 1; end
    if (s == 4) begin m2r = 1; rw = 1; dn = 1; end
    if (s == 5) begin mw = 1; iod = 1; dn = mr; end
    if (s == 6) begin sa = 1; alu = 2'b10; end
    if (s == 7) begin rd = 1; rw = 1; dn = 1; end
    if (s == 8) begin sa = 1; alu = 2'b01; pwc = 1; pcs = 2'b01; dn = 1; end
    if (s == 9) begin pw = 1; pcs = 2'b10; dn = 1; end
    if (s == 10) begin sa = 1; srcb = 2'b10; end
    if (s == 11) begin rw = 1; dn = 1; end
    return {alu, rd, sa, iod, m2r, srcb, pcs, mrd, mw, irw, rw, pw, pwc, dn};
  endfunction

  function automatic logic [16:0] obsv();
    return {bus.OpALU, bus.RegDst, bus.ALUSrcA, bus.IorD, bus.MemtoReg, bus.ALUSrcB, bus.PCSource,
            bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.PCWrite, bus.PCWriteCond, bus.instr_done};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input int s, input logic mr);
    logic ill;
    bus.mem_ready = mr;
    ill = pend;
    pend = (s == 1) && !legal(bus.opcode);
    @(negedge clk);
    check("state", 32'(bus.state_o), 32'(s));
    check("outs", 32'(obsv()), 32'(expv(s, mr)));
    check("illegal", 32'(bus.illegal_op), 32'(ill));
    n_done += int'(bus.instr_done);
    n_rw += int'(bus.RegWrite);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [5:0] op, input int fst, input int mst);
    bit wr;
    n_done = 0;
    n_rw = 0;
    bus.opcode = op;
    repeat (fst) cyc(0, 1'b0);
    cyc(0, 1'b1);
    cyc(1, 1'($urandom));
    if (op == RT) begin cyc(6, 1'($urandom)); cyc(7, 1'($urandom)); end
    if (op == LW) begin
      cyc(2, 1'($urandom));
      repeat (mst) cyc(3, 1'b0);
      cyc(3, 1'b1);
      cyc(4, 1'($urandom));
    end
    if (op == SW) begin
      cyc(2, 1'($urandom));
      repeat (mst) cyc(5, 1'b0);
      cyc(5, 1'b1);
    end
    if (op == BQ) cyc(8, 1'($urandom));
    if (op == JP) cyc(9, 1'($urandom));
    if (op == AI) begin cyc(10, 1'($urandom)); cyc(11, 1'($urandom)); end
    wr = op == RT || op == LW || op == AI;
    check("done_cnt", 32'(n_done), 32'(legal(op)));
    check("regwrite_cnt", 32'(n_rw), 32'(wr));
  endtask

  initial begin
    logic [5:0] ops [6];
    logic [5:0] o;
    ops = '{RT, LW, SW, BQ, JP, AI};
    bus.opcode = 6'd0;
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outs", 32'(obsv()), 32'd0);
    check("rst_state", 32'(bus.state_o), 32'd0);
    check("rst_illegal", 32'(bus.illegal_op), 32'd0);
    rst_n = 1'b1;
    run_instr(RT, 0, 0);
    run_instr(LW, 1, 3);
    run_instr(SW, 0, 2);
    run_instr(BQ, 0, 0);
    run_instr(JP, 0, 0);
    run_instr(AI, 0, 0);
    run_instr(6'b111111, 0, 0);
    run_instr(RT, 0, 0);
    // abort an R-type in EXEC with an asynchronous reset
    bus.opcode = RT;
    cyc(0, 1'b1);
    cyc(1, 1'b1);
    bus.mem_ready = 1'b1;
    #1;
    check("exec_before_rst", 32'(bus.state_o), 32'd6);
    rst_n = 1'b0;
    pend = 1'b0;
    #1;
    check("async_rst_outs", 32'(obsv()), 32'd0);
    check("async_rst_state", 32'(bus.state_o), 32'd0);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    check("post_rst_outs", 32'(obsv()), 32'(expv(0, 1'b0)));
    @(posedge clk);
    #1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 6) == 0) begin
        do o = 6'($urandom); while (legal(o));
      end else o = ops[$urandom_range(0, 5)];
      run_instr(o, $urandom_range(0, 2), $urandom_range(0, 3));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
